// File: rtl/arith_reservation_station.sv
// Data-capture reservation station for the arithmetic pipeline: a collapsing queue
// that snoops writeback for missing operands/flags and issues the oldest ready uop.
module arith_reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       disp_valid,
  output logic       disp_ready,
  input  logic [3:0] disp_opcode,
  input  logic [4:0] disp_rob_entry,
  input  logic [4:0] disp_dest_reg,
  input  logic [4:0] disp_flag_reg,
  input  logic [7:0] disp_arch_dest_regs,
  input  logic [4:0] disp_a_tag,
  input  logic [4:0] disp_b_tag,
  input  logic [4:0] disp_f_tag,
  input  logic [7:0] disp_a_val,
  input  logic [7:0] disp_b_val,
  input  logic [7:0] disp_f_val,
  input  logic       disp_a_rdy,
  input  logic       disp_b_rdy,
  input  logic       disp_f_rdy,
  input  logic       wb_valid,
  input  logic [4:0] wb_dest_reg,
  input  logic [4:0] wb_flag_reg,
  input  logic [7:0] wb_result_val,
  input  logic [7:0] wb_result_flags,
  output logic       issue_valid,
  output logic [3:0] issue_opcode,
  output logic [4:0] issue_rob_entry,
  output logic [4:0] issue_dest_reg,
  output logic [4:0] issue_flag_reg,
  output logic [7:0] issue_op_a_val,
  output logic [7:0] issue_op_b_val,
  output logic [7:0] issue_flags_val,
  output logic [7:0] issue_arch_dest_regs
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0] opcode;
    logic [4:0] rob_entry;
    logic [4:0] dest_reg;
    logic [4:0] flag_reg;
    logic [7:0] arch_dest_regs;
    logic [4:0] a_tag;
    logic [4:0] b_tag;
    logic [4:0] f_tag;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] f_val;
    logic       a_rdy;
    logic       b_rdy;
    logic       f_rdy;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        cap_s [DEPTH];
  entry_t        new_s;
  entry_t        shifted_s;
  entry_t        issue_s;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_after_s;
  logic [IW-1:0] sel_idx_s;
  logic          sel_found_s;
  logic          issue_fire_s;
  logic          accept_s;

  // Writeback snoop: fill any operand still waiting on the broadcast tag.
  function automatic entry_t snoop(input entry_t e, input logic wv,
                                   input logic [4:0] wd, input logic [4:0] wf,
                                   input logic [7:0] rv, input logic [7:0] rf);
    entry_t r;
    r = e;
    if (wv && !e.a_rdy && (e.a_tag == wd)) begin
      r.a_val = rv;
      r.a_rdy = 1'b1;
    end
    if (wv && !e.b_rdy && (e.b_tag == wd)) begin
      r.b_val = rv;
      r.b_rdy = 1'b1;
    end
    if (wv && !e.f_rdy && (e.f_tag == wf)) begin
      r.f_val = rf;
      r.f_rdy = 1'b1;
    end
    return r;
  endfunction

  assign disp_ready = rst_n & ~flush & (count_q < CW'(DEPTH));

  // Oldest-ready select; downward scan so the lowest index wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      logic hit;
      hit = (i < int'(count_q)) && ent_q[i].a_rdy && ent_q[i].b_rdy && ent_q[i].f_rdy;
      sel_idx_s   = hit ? IW'(i) : sel_idx_s;
      sel_found_s = sel_found_s | hit;
    end
    issue_fire_s = rst_n & sel_found_s;
    issue_s      = issue_fire_s ? ent_q[sel_idx_s] : '0;
  end

  assign issue_valid          = issue_fire_s;
  assign issue_opcode         = issue_s.opcode;
  assign issue_rob_entry      = issue_s.rob_entry;
  assign issue_dest_reg       = issue_s.dest_reg;
  assign issue_flag_reg       = issue_s.flag_reg;
  assign issue_op_a_val       = issue_s.a_val;
  assign issue_op_b_val       = issue_s.b_val;
  assign issue_flags_val      = issue_s.f_val;
  assign issue_arch_dest_regs = issue_s.arch_dest_regs;

  // Next state: capture, collapse above the issued slot, append the dispatch.
  always_comb begin
    accept_s      = disp_valid & disp_ready;
    count_after_s = count_q - CW'(issue_fire_s);
    new_s = snoop('{opcode: disp_opcode, rob_entry: disp_rob_entry,
                    dest_reg: disp_dest_reg, flag_reg: disp_flag_reg,
                    arch_dest_regs: disp_arch_dest_regs,
                    a_tag: disp_a_tag, b_tag: disp_b_tag, f_tag: disp_f_tag,
                    a_val: disp_a_val, b_val: disp_b_val, f_val: disp_f_val,
                    a_rdy: disp_a_rdy, b_rdy: disp_b_rdy, f_rdy: disp_f_rdy},
                  wb_valid, wb_dest_reg, wb_flag_reg, wb_result_val, wb_result_flags);
    for (int i = 0; i < DEPTH; i++) begin
      cap_s[i] = snoop(ent_q[i], wb_valid, wb_dest_reg, wb_flag_reg,
                       wb_result_val, wb_result_flags);
    end
    shifted_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // The modulo only keeps the index legal; the top slot never reads it.
      shifted_s = (issue_fire_s && (i >= int'(sel_idx_s)) && (i + 1 < DEPTH))
                  ? cap_s[(i + 1) % DEPTH] : cap_s[i];
      if (flush) begin
        ent_d[i] = '0;
      end else if (i < int'(count_after_s)) begin
        ent_d[i] = shifted_s;
      end else if (accept_s && (i == int'(count_after_s))) begin
        ent_d[i] = new_s;
      end else begin
        ent_d[i] = '0;
      end
    end
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_after_s + CW'(accept_s);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_arith_reservation_station.sv
// Randomised + directed bench for arith_reservation_station against a queue-based
// model of the station, compared on every cycle.
module tb_arith_reservation_station;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] opcode;
    logic [4:0] rob;
    logic [4:0] dest;
    logic [4:0] flag;
    logic [7:0] arch;
    logic [4:0] a_tag;
    logic [4:0] b_tag;
    logic [4:0] f_tag;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] f_val;
    logic       a_rdy;
    logic       b_rdy;
    logic       f_rdy;
  } uop_t;

  logic clk, rst_n, flush, disp_valid, disp_ready, wb_valid;
  logic [4:0] wb_dest_reg, wb_flag_reg;
  logic [7:0] wb_result_val, wb_result_flags;
  uop_t din;
  logic       issue_valid;
  logic [3:0] issue_opcode;
  logic [4:0] issue_rob_entry, issue_dest_reg, issue_flag_reg;
  logic [7:0] issue_op_a_val, issue_op_b_val, issue_flags_val, issue_arch_dest_regs;

  uop_t q[$];
  int total = 0;
  int bad = 0;

  arith_reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(din.opcode), .disp_rob_entry(din.rob),
    .disp_dest_reg(din.dest), .disp_flag_reg(din.flag),
    .disp_arch_dest_regs(din.arch),
    .disp_a_tag(din.a_tag), .disp_b_tag(din.b_tag), .disp_f_tag(din.f_tag),
    .disp_a_val(din.a_val), .disp_b_val(din.b_val), .disp_f_val(din.f_val),
    .disp_a_rdy(din.a_rdy), .disp_b_rdy(din.b_rdy), .disp_f_rdy(din.f_rdy),
    .wb_valid(wb_valid), .wb_dest_reg(wb_dest_reg), .wb_flag_reg(wb_flag_reg),
    .wb_result_val(wb_result_val), .wb_result_flags(wb_result_flags),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rob_entry(issue_rob_entry), .issue_dest_reg(issue_dest_reg),
    .issue_flag_reg(issue_flag_reg), .issue_op_a_val(issue_op_a_val),
    .issue_op_b_val(issue_op_b_val), .issue_flags_val(issue_flags_val),
    .issue_arch_dest_regs(issue_arch_dest_regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic uop_t snoop(input uop_t e);
    uop_t r = e;
    if (wb_valid) begin
      if (!r.a_rdy && r.a_tag == wb_dest_reg) begin r.a_val = wb_result_val; r.a_rdy = 1'b1; end
      if (!r.b_rdy && r.b_tag == wb_dest_reg) begin r.b_val = wb_result_val; r.b_rdy = 1'b1; end
      if (!r.f_rdy && r.f_tag == wb_flag_reg) begin r.f_val = wb_result_flags; r.f_rdy = 1'b1; end
    end
    return r;
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].a_rdy && q[i].b_rdy && q[i].f_rdy) return i;
    return -1;
  endfunction

  function automatic logic [51:0] exp_issue();
    int k = oldest_ready();
    if (!rst_n || k < 0) return '0;
    return {1'b1, q[k].opcode, q[k].rob, q[k].dest, q[k].flag,
            q[k].a_val, q[k].b_val, q[k].f_val, q[k].arch};
  endfunction

  function automatic logic exp_ready();
    return rst_n && !flush && (q.size() < DEPTH);
  endfunction

  task automatic model_update();
    int  k   = oldest_ready();
    bit  acc = disp_valid && exp_ready();
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) q[i] = snoop(q[i]);
      if (k >= 0) q.delete(k);
      if (acc) q.push_back(snoop(din));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic cyc();
    logic [51:0] act;
    @(negedge clk);
    act = {issue_valid, issue_opcode, issue_rob_entry, issue_dest_reg, issue_flag_reg,
           issue_op_a_val, issue_op_b_val, issue_flags_val, issue_arch_dest_regs};
    total++;
    if (act !== exp_issue()) begin
      bad++;
      $display("FAIL issue_bus: got %h expected %h", act, exp_issue());
    end
    total++;
    if (disp_ready !== exp_ready()) begin
      bad++;
      $display("FAIL disp_ready: got %b expected %b", disp_ready, exp_ready());
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic put(input logic [4:0] rob, input logic a_rdy, input logic [4:0] a_tag,
                     input logic f_rdy, input logic [4:0] f_tag);
    din.opcode = 4'($urandom_range(0, 15));
    din.rob    = rob;
    din.dest   = 5'($urandom_range(0, 31));
    din.flag   = 5'($urandom_range(0, 31));
    din.arch   = 8'($urandom_range(0, 255));
    din.a_val  = 8'($urandom_range(0, 255));
    din.b_val  = 8'($urandom_range(0, 255));
    din.f_val  = 8'($urandom_range(0, 255));
    din.a_rdy  = a_rdy;
    din.a_tag  = a_tag;
    din.b_rdy  = 1'b1;
    din.b_tag  = 5'd31;
    din.f_rdy  = f_rdy;
    din.f_tag  = f_tag;
    disp_valid = 1'b1;
  endtask

  task automatic wb(input logic [4:0] d, input logic [4:0] f, input logic [7:0] v, input logic [7:0] fl);
    wb_valid = 1'b1; wb_dest_reg = d; wb_flag_reg = f; wb_result_val = v; wb_result_flags = fl;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; din = '0;
    wb_valid = 1'b0; wb_dest_reg = '0; wb_flag_reg = '0; wb_result_val = '0; wb_result_flags = '0;
    cyc(); cyc();
    chk("reset_disp_ready", 32'(disp_ready), 32'd0);
    chk("reset_issue_valid", 32'(issue_valid), 32'd0);
    rst_n = 1'b1; #1;
    chk("post_reset_disp_ready", 32'(disp_ready), 32'd1);

    // three ready uops issue in order
    put(5'd1, 1'b1, 5'd31, 1'b1, 5'd31); cyc();
    chk("t1_rob1", 32'({issue_valid, issue_rob_entry}), 32'h21);
    put(5'd2, 1'b1, 5'd31, 1'b1, 5'd31); cyc();
    chk("t1_rob2", 32'({issue_valid, issue_rob_entry}), 32'h22);
    put(5'd3, 1'b1, 5'd31, 1'b1, 5'd31); cyc();
    chk("t1_rob3", 32'({issue_valid, issue_rob_entry}), 32'h23);
    disp_valid = 1'b0; cyc();
    chk("t1_empty", 32'(issue_valid), 32'd0);

    // younger ready uop overtakes; wakeup of the older one
    put(5'd5, 1'b0, 5'd9, 1'b1, 5'd31); cyc();
    chk("t2_wait", 32'(issue_valid), 32'd0);
    put(5'd6, 1'b1, 5'd31, 1'b1, 5'd31); cyc();
    chk("t2_rob6", 32'({issue_valid, issue_rob_entry}), 32'h26);
    disp_valid = 1'b0; wb(5'd9, 5'd31, 8'h5A, 8'h00); cyc();
    wb_valid = 1'b0;
    chk("t2_rob5", 32'({issue_valid, issue_rob_entry}), 32'h25);
    chk("t2_a_val", 32'(issue_op_a_val), 32'h5A);
    cyc();

    // flag bypass in the dispatch cycle
    put(5'd7, 1'b1, 5'd31, 1'b0, 5'd3); wb(5'd30, 5'd3, 8'h00, 8'h81); cyc();
    disp_valid = 1'b0; wb_valid = 1'b0;
    chk("t3_rob7", 32'({issue_valid, issue_rob_entry}), 32'h27);
    chk("t3_flags", 32'(issue_flags_val), 32'h81);
    cyc();

    // fill, wake slot 2, collapse, refill at slot 3
    for (int i = 0; i < 4; i++) begin
      put(5'(10 + i), 1'b0, 5'(16 + i), 1'b1, 5'd31); cyc();
    end
    disp_valid = 1'b0; #1;
    chk("t4_full", 32'(disp_ready), 32'd0);
    wb(5'd18, 5'd31, 8'h33, 8'h00); cyc();
    wb_valid = 1'b0;
    put(5'd14, 1'b1, 5'd31, 1'b1, 5'd31); #1;
    chk("t4_full_while_issue", 32'(disp_ready), 32'd0);
    chk("t4_rob12", 32'({issue_valid, issue_rob_entry}), 32'h2C);
    chk("t4_a_val", 32'(issue_op_a_val), 32'h33);
    cyc();
    disp_valid = 1'b0; #1;
    chk("t4_ready_again", 32'(disp_ready), 32'd1);
    chk("t4_no_issue", 32'(issue_valid), 32'd0);
    put(5'd15, 1'b1, 5'd31, 1'b1, 5'd31); cyc();
    disp_valid = 1'b0;
    chk("t4_rob15", 32'({issue_valid, issue_rob_entry}), 32'h2F);
    cyc();

    // flush with a concurrent dispatch
    flush = 1'b1; put(5'd20, 1'b1, 5'd31, 1'b1, 5'd31); #1;
    chk("t5_flush_ready", 32'(disp_ready), 32'd0);
    cyc();
    flush = 1'b0; disp_valid = 1'b0; #1;
    chk("t5_after_issue", 32'(issue_valid), 32'd0);
    chk("t5_after_ready", 32'(disp_ready), 32'd1);
    wb(5'd16, 5'd31, 8'h44, 8'h00); cyc();
    wb_valid = 1'b0;
    chk("t5_no_stale", 32'(issue_valid), 32'd0);

    // reset mid-operation with two ready entries
    put(5'd21, 1'b0, 5'd25, 1'b1, 5'd31); cyc();
    put(5'd22, 1'b0, 5'd25, 1'b1, 5'd31); cyc();
    disp_valid = 1'b0; wb(5'd25, 5'd31, 8'h11, 8'h00); cyc();
    wb_valid = 1'b0;
    chk("t6_rob21", 32'({issue_valid, issue_rob_entry}), 32'h35);
    rst_n = 1'b0; #1;
    chk("t6_in_reset", 32'(issue_valid), 32'd0);
    cyc();
    rst_n = 1'b1; #1;
    chk("t6_after_reset", 32'(issue_valid), 32'd0);
    cyc();
    chk("t6_no_stale", 32'(issue_valid), 32'd0);

    // randomised traffic
    for (int n = 0; n < 2000; n++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      disp_valid = ($urandom_range(0, 99) < 60);
      din.opcode = 4'($urandom_range(0, 15));
      din.rob    = 5'($urandom_range(0, 31));
      din.dest   = 5'($urandom_range(0, 31));
      din.flag   = 5'($urandom_range(0, 31));
      din.arch   = 8'($urandom_range(0, 255));
      din.a_tag  = 5'($urandom_range(0, 7));
      din.b_tag  = 5'($urandom_range(0, 7));
      din.f_tag  = 5'($urandom_range(0, 7));
      din.a_val  = 8'($urandom_range(0, 255));
      din.b_val  = 8'($urandom_range(0, 255));
      din.f_val  = 8'($urandom_range(0, 255));
      din.a_rdy  = ($urandom_range(0, 2) != 0);
      din.b_rdy  = ($urandom_range(0, 2) != 0);
      din.f_rdy  = ($urandom_range(0, 2) != 0);
      wb_valid        = ($urandom_range(0, 1) == 1);
      wb_dest_reg     = 5'($urandom_range(0, 7));
      wb_flag_reg     = 5'($urandom_range(0, 7));
      wb_result_val   = 8'($urandom_range(0, 255));
      wb_result_flags = 8'($urandom_range(0, 255));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
